// File: rtl/gpr_wb_arbiter.sv
// Purpose : round-robin write-back arbiter for the single GPR write port, plus
//           a per-register pending-write (busy) scoreboard for decode stalls.
// Latency : grant is combinational in cycle N; gpr_we_/addr/data are registered
//           and drive the register file in N+1; busy clears at the end of N+1.
// Backpressure: the register file never stalls, so every granted request
//           completes in its grant cycle; losers simply keep wb_req asserted.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-low reset
//   wb_req/addr/data  per-requester write-back request; slice i is requester i
//   wb_ack            one-hot combinational grant (transfer = wb_req & wb_ack)
//   gpr_we_           register file write enable, active-low, registered
//   gpr_wr_addr/data  register file write address/data, registered
//   rsv_en/rsv_addr   decode-stage destination reservation
//   busy              per-register pending-write flags, busy[0] tied to 0
module gpr_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          wb_req,
    input  logic [NREQ*ADDR_W-1:0]   wb_addr,
    input  logic [NREQ*DATA_W-1:0]   wb_data,
    output logic [NREQ-1:0]          wb_ack,
    output logic                     gpr_we_,
    output logic [ADDR_W-1:0]        gpr_wr_addr,
    output logic [DATA_W-1:0]        gpr_wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(2**ADDR_W)-1:0]   busy
);

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG   = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]   r_ptr;
    logic               r_we_n;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic [NREG-1:0]    r_busy;

    // ------------------------------------------------------------------
    // Combinational arbitration signals
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]   w_cand     [NREQ];
    logic [ADDR_W-1:0]  w_addr_arr [NREQ];
    logic [DATA_W-1:0]  w_data_arr [NREQ];
    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [NREQ-1:0]    w_ack;
    logic [ADDR_W-1:0]  w_gnt_addr;
    logic [DATA_W-1:0]  w_gnt_data;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [NREG-1:0]    w_busy_nxt;

    // Unpack the flat request buses and build the search order.
    // w_cand[k] is the k-th requester examined, i.e. (ptr + k) mod NREQ.
    // ptr < NREQ and k < NREQ, so one conditional subtract is enough.
    for (genvar k = 0; k < NREQ; k++) begin : g_req
        logic [PTR_W:0] w_sum;

        assign w_addr_arr[k] = wb_addr[k*ADDR_W +: ADDR_W];
        assign w_data_arr[k] = wb_data[k*DATA_W +: DATA_W];

        assign w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
        assign w_cand[k] = (w_sum >= (PTR_W+1)'(NREQ))
                         ? PTR_W'(w_sum - (PTR_W+1)'(NREQ))
                         : w_sum[PTR_W-1:0];
    end

    // First requesting candidate in search order wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_ack     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt_vld && wb_req[w_cand[k]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand[k];
            end
        end
        if (w_gnt_vld) begin
            w_ack[w_gnt_idx] = 1'b1;
        end
    end

    assign w_gnt_addr = w_addr_arr[w_gnt_idx];
    assign w_gnt_data = w_data_arr[w_gnt_idx];

    // Pointer moves just past the winner so it becomes lowest priority.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_gnt_vld) begin
            if (w_gnt_idx == PTR_W'(NREQ - 1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = w_gnt_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state. The clear from the retiring write is applied
    // first so a same-edge reservation of that register overrides it: the
    // reservation belongs to a younger instruction whose write is still
    // outstanding.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = r_busy;
        if (!r_we_n) begin
            w_busy_nxt[r_wr_addr] = 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Write stage. Writes to register 0 are acknowledged and captured but
    // never enabled, so the hardwired zero register is not disturbed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we_n    <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_gnt_vld) begin
            r_we_n    <= (w_gnt_addr == '0);
            r_wr_addr <= w_gnt_addr;
            r_wr_data <= w_gnt_data;
        end else begin
            r_we_n    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: only wb_ack is combinational; the write port is registered.
    // ------------------------------------------------------------------
    assign wb_ack      = w_ack;
    assign gpr_we_     = r_we_n;
    assign gpr_wr_addr = r_wr_addr;
    assign gpr_wr_data = r_wr_data;
    assign busy        = r_busy;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                     clk;
    logic                     reset;
    logic [NREQ-1:0]          wb_req;
    logic [NREQ*ADDR_W-1:0]   wb_addr;
    logic [NREQ*DATA_W-1:0]   wb_data;
    logic [NREQ-1:0]          wb_ack;
    logic                     gpr_we_;
    logic [ADDR_W-1:0]        gpr_wr_addr;
    logic [DATA_W-1:0]        gpr_wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [(2**ADDR_W)-1:0]   busy;

    int n_assert;
    int n_fail;

    gpr_wb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_req      (wb_req),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_ack      (wb_ack),
        .gpr_we_     (gpr_we_),
        .gpr_wr_addr (gpr_wr_addr),
        .gpr_wr_data (gpr_wr_data),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start of a cycle: just after the rising edge, all inputs idle.
    task automatic tick();
        @(posedge clk);
        #1;
        wb_req = '0;
        rsv_en = 1'b0;
    endtask

    // Sample point for the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_req(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_req[idx] = 1'b1;
        wb_addr[idx*ADDR_W +: ADDR_W] = a;
        wb_data[idx*DATA_W +: DATA_W] = d;
    endtask

    task automatic reserve(input logic [ADDR_W-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    logic [NREQ-1:0]   exp_ack [6];
    logic [ADDR_W-1:0] exp_adr [6];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        wb_req   = '0;
        wb_addr  = '0;
        wb_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;

        // ---------------- reset values ----------------
        sample();
        sample();
        chk("rst_we_held", 64'(gpr_we_), 64'h1);
        chk("rst_busy_held", 64'(busy), 64'h0);
        #2 reset = 1'b1;
        tick();
        sample();
        chk("rst_we", 64'(gpr_we_), 64'h1);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ack", 64'(wb_ack), 64'h0);
        chk("rst_addr", 64'(gpr_wr_addr), 64'h0);
        chk("rst_data", 64'(gpr_wr_data), 64'h0);

        // ---------------- single write ----------------
        tick();
        drive_req(1, 5'd7, 32'hDEAD_BEEF);
        sample();
        chk("single_ack", 64'(wb_ack), 64'h2);
        chk("single_we_grant_cyc", 64'(gpr_we_), 64'h1);
        tick();
        sample();
        chk("single_we", 64'(gpr_we_), 64'h0);
        chk("single_addr", 64'(gpr_wr_addr), 64'd7);
        chk("single_data", 64'(gpr_wr_data), 64'hDEAD_BEEF);
        chk("single_ack_idle", 64'(wb_ack), 64'h0);
        tick();
        sample();
        chk("single_we_done", 64'(gpr_we_), 64'h1);
        chk("single_addr_hold", 64'(gpr_wr_addr), 64'd7);

        // Re-reset so round-robin starts from requester 0.
        #2 reset = 1'b0;
        #2 reset = 1'b1;

        // ---------------- round-robin ----------------
        exp_ack[0] = 3'b001; exp_adr[0] = 5'd1;
        exp_ack[1] = 3'b010; exp_adr[1] = 5'd2;
        exp_ack[2] = 3'b100; exp_adr[2] = 5'd3;
        exp_ack[3] = 3'b001; exp_adr[3] = 5'd1;
        exp_ack[4] = 3'b010; exp_adr[4] = 5'd2;
        exp_ack[5] = 3'b100; exp_adr[5] = 5'd3;
        for (int c = 0; c < 6; c++) begin
            tick();
            drive_req(0, 5'd1, 32'hA000_0001);
            drive_req(1, 5'd2, 32'hA000_0002);
            drive_req(2, 5'd3, 32'hA000_0003);
            sample();
            chk($sformatf("rr_ack_%0d", c), 64'(wb_ack), 64'(exp_ack[c]));
            if (c == 0) begin
                chk("rr_we_first", 64'(gpr_we_), 64'h1);
            end else begin
                chk($sformatf("rr_we_%0d", c), 64'(gpr_we_), 64'h0);
                chk($sformatf("rr_addr_%0d", c), 64'(gpr_wr_addr), 64'(exp_adr[c-1]));
            end
        end
        tick();
        sample();
        chk("rr_ack_idle", 64'(wb_ack), 64'h0);
        chk("rr_we_last", 64'(gpr_we_), 64'h0);
        chk("rr_addr_last", 64'(gpr_wr_addr), 64'd3);
        chk("rr_data_last", 64'(gpr_wr_data), 64'hA000_0003);
        tick();
        sample();
        chk("rr_we_end", 64'(gpr_we_), 64'h1);

        // ---------------- scoreboard (ptr = 0) ----------------
        tick();
        reserve(5'd5);
        sample();
        chk("sb_c0_busy5", 64'(busy[5]), 64'h0);
        tick();
        sample();
        chk("sb_c1_busy5", 64'(busy[5]), 64'h1);
        tick();
        sample();
        chk("sb_c2_busy5", 64'(busy[5]), 64'h1);
        tick();
        drive_req(2, 5'd5, 32'h0000_0055);
        sample();
        chk("sb_c3_ack", 64'(wb_ack), 64'h4);
        chk("sb_c3_busy5", 64'(busy[5]), 64'h1);
        tick();
        sample();
        chk("sb_c4_we", 64'(gpr_we_), 64'h0);
        chk("sb_c4_addr", 64'(gpr_wr_addr), 64'd5);
        chk("sb_c4_busy5", 64'(busy[5]), 64'h1);
        tick();
        sample();
        chk("sb_c5_busy5", 64'(busy[5]), 64'h0);
        chk("sb_c5_we", 64'(gpr_we_), 64'h1);

        // ---------------- set/clear collision (ptr = 0) ----------------
        tick();
        reserve(5'd9);
        sample();
        tick();
        drive_req(0, 5'd9, 32'h0000_0099);
        sample();
        chk("col_ack", 64'(wb_ack), 64'h1);
        chk("col_busy9_c1", 64'(busy[9]), 64'h1);
        tick();
        reserve(5'd9);
        sample();
        chk("col_we", 64'(gpr_we_), 64'h0);
        chk("col_addr", 64'(gpr_wr_addr), 64'd9);
        tick();
        drive_req(1, 5'd9, 32'h0000_009A);
        sample();
        chk("col_busy9_kept", 64'(busy[9]), 64'h1);
        chk("col_ack2", 64'(wb_ack), 64'h2);
        tick();
        sample();
        chk("col_we2", 64'(gpr_we_), 64'h0);
        chk("col_data2", 64'(gpr_wr_data), 64'h0000_009A);
        chk("col_busy9_c4", 64'(busy[9]), 64'h1);
        tick();
        sample();
        chk("col_busy9_clr", 64'(busy[9]), 64'h0);

        // ---------------- register 0 (ptr = 2, wraps to 0) ----------------
        tick();
        reserve(5'd0);
        drive_req(0, 5'd0, 32'h0000_00AA);
        sample();
        chk("r0_ack", 64'(wb_ack), 64'h1);
        tick();
        sample();
        chk("r0_we", 64'(gpr_we_), 64'h1);
        chk("r0_busy", 64'(busy), 64'h0);
        chk("r0_addr", 64'(gpr_wr_addr), 64'd0);
        chk("r0_data", 64'(gpr_wr_data), 64'h0000_00AA);

        // ---------------- mid-operation reset (ptr = 1) ----------------
        tick();
        reserve(5'd12);
        sample();
        tick();
        drive_req(1, 5'd12, 32'h0000_1234);
        sample();
        chk("mr_busy12", 64'(busy[12]), 64'h1);
        chk("mr_ack", 64'(wb_ack), 64'h2);
        #2;
        wb_req = '0;
        reset  = 1'b0;
        #1;
        chk("mr_we_async", 64'(gpr_we_), 64'h1);
        chk("mr_busy_async", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        sample();
        chk("mr_we_in_rst", 64'(gpr_we_), 64'h1);
        chk("mr_addr_in_rst", 64'(gpr_wr_addr), 64'd0);
        #2 reset = 1'b1;
        tick();
        sample();
        chk("mr_we_rel", 64'(gpr_we_), 64'h1);
        chk("mr_busy_rel", 64'(busy), 64'h0);
        chk("mr_data_rel", 64'(gpr_wr_data), 64'h0);
        tick();
        drive_req(0, 5'd1, 32'h1);
        drive_req(1, 5'd2, 32'h2);
        drive_req(2, 5'd3, 32'h3);
        sample();
        chk("mr_ptr0_ack", 64'(wb_ack), 64'h1);
        tick();
        drive_req(1, 5'd2, 32'h2);
        drive_req(2, 5'd3, 32'h3);
        sample();
        chk("mr_next_ack", 64'(wb_ack), 64'h2);
        chk("mr_next_we", 64'(gpr_we_), 64'h0);
        chk("mr_next_addr", 64'(gpr_wr_addr), 64'd1);
        tick();
        sample();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-back arbiter and pending-write scoreboard for the single-write-port general purpose register file. It takes write-back requests from up to NREQ execution units (ALU, load unit, multiply/divide unit) and grants one per cycle in round-robin order. It drives the register file write port from registered outputs. It also keeps a per-register busy bitmap so the decode stage can stall on registers that still have a write pending.

## Interface
- NREQ, 3: number of write-back requesters; requester 0 has highest priority after reset.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_req  in  NREQ  per-requester write-back request.
- wb_addr  in  NREQ*ADDR_W  per-requester destination register; slice i belongs to requester i.
- wb_data  in  NREQ*DATA_W  per-requester write data.
- wb_ack  out  NREQ  one-hot grant; a transfer happens when wb_req[i] and wb_ack[i] are both high.
- gpr_we_  out  1  register file write enable, active-low.
- gpr_wr_addr  out  ADDR_W  register file write address.
- gpr_wr_data  out  DATA_W  register file write data.
- rsv_en  in  1  decode stage reserves a destination register this cycle.
- rsv_addr  in  ADDR_W  register being reserved.
- busy  out  2**ADDR_W  per-register pending-write flags; busy[0] is always 0.

## Operation
- Arbitration:
  - Round-robin pointer ptr ranges over 0..NREQ-1 and resets to 0.
  - The grant goes to the first requester with wb_req high, searching from ptr upward with wrap.
  - wb_ack is combinational from wb_req and ptr; at most one bit is high, and no bit is high when there are no requests.
  - After a grant to requester g, ptr becomes (g+1) mod NREQ. With no grant, ptr holds.
  - The register file never back-pressures, so a granted request always completes in that cycle.
- Write stage (registered):
  - On a grant, capture the granted address and data into gpr_wr_addr and gpr_wr_data.
  - gpr_we_ is driven low the next cycle, except when the granted address is 0. Such writes are acknowledged but dropped: gpr_we_ stays high.
  - With no grant, gpr_we_ returns high. Address and data hold their last values.
- Scoreboard:
  - When rsv_en is high and rsv_addr is nonzero, set busy[rsv_addr].
  - A write leaving the write stage (gpr_we_ low this cycle) clears busy[gpr_wr_addr] at the same edge.
  - Set and clear of the same register at the same edge: set wins, because the new reservation is younger.
  - Reserving a register that is already busy is legal; busy stays 1. Busy is a flag, not a count, and decode must stall on busy before reserving.
  - Reservation of register 0 is ignored.
- Reset (asynchronous, any time): busy = 0, ptr = 0, gpr_we_ = 1, gpr_wr_addr = 0, gpr_wr_data = 0. A write captured but not yet driven is discarded.

## Timing
- Request accepted in cycle N means gpr_we_ is low for exactly one cycle, N+1, with that address and data. The register file commits at the end of N+1.
- Register file read-port bypass makes the data visible to readers during N+1.
- busy[a] for that write reads 0 from cycle N+2.
- rsv_en in cycle N means busy[rsv_addr] reads 1 from cycle N+1.
- Sustained throughput is one write per cycle. A continuously requesting requester waits at most NREQ-1 cycles between grants.
- The arbiter has no combinational path from any input to gpr_we_, gpr_wr_addr or gpr_wr_data.

## Test plan
- Reset values: hold reset low, then release -> gpr_we_=1, busy=0, wb_ack=0. Then a single wb_req[1] with addr 7 and data 0xDEADBEEF -> wb_ack=3'b010 the same cycle; next cycle gpr_we_=0, addr 7, data 0xDEADBEEF.
- Round-robin: all three requesters hold wb_req=1 for 6 cycles -> grant sequence 0,1,2,0,1,2, and gpr_we_ is low for 6 consecutive cycles starting one cycle after the first grant.
- Scoreboard: rsv_en with addr 5 in cycle 0, then wb_req[2] with addr 5 in cycle 3 -> busy[5]=1 from cycle 1 through cycle 4, and busy[5]=0 from cycle 5.
- Set/clear collision: the write to r9 retiring in the same cycle as rsv_en on addr 9 -> busy[9] stays 1.
- Register 0: rsv_en on addr 0 together with wb_req[0] on addr 0 -> wb_ack[0]=1, gpr_we_ stays 1, busy[0]=0.
- Mid-operation reset: assert reset asynchronously between a grant and its write cycle -> gpr_we_=1 immediately, the write is never issued, busy=0 and ptr=0 on release.
